// File: rtl/blink_pkg.sv
// Shared types and default timing for the blink channel transmitter and receiver.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } blink_state_e;

    localparam int FRAME_BITS = 8;

    localparam int DEF_CNT_W           = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_LONG_THRESH     = 2000;
    localparam int DEF_MAX_MARK        = 8000;
    localparam int DEF_GAP_TIMEOUT     = 10000;

endpackage

// File: rtl/blink_pulse_rx_if.sv
// Pin and status/data signals of the blink receiver.
// The master side drives the raw pin; the slave side is the receiver itself.
interface blink_pulse_rx_if;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
    logic [3:0] bit_cnt;

    modport master (
        output rx_in,
        input  data_out, data_valid, frame_err, busy, bit_cnt
    );

    modport slave (
        input  rx_in,
        output data_out, data_valid, frame_err, busy, bit_cnt
    );
endinterface

// File: rtl/blink_debounce.sv
// Two-flop synchronizer plus debounce filter for the raw blink pin.
// Emits the filtered level and one-cycle rise/fall flags aligned with level changes.
module blink_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_rise;
    logic            r_fall;
    logic [DB_W-1:0] r_dbCnt;
    logic            w_settled;

    // The synchronized input must disagree with the filtered level for DEBOUNCE_CYCLES cycles in a row.
    assign w_settled = (r_sync2 != r_level) && (r_dbCnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_dbCnt <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= w_settled && r_sync2;
            r_fall  <= w_settled && !r_sync2;
            if ((r_sync2 == r_level) || w_settled) begin
                r_dbCnt <= '0;
            end else begin
                r_dbCnt <= r_dbCnt + DB_W'(1);
            end
            if (w_settled) begin
                r_level <= r_sync2;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
endmodule

// File: rtl/blink_pulse_rx.sv
// Blink channel receiver: decodes short/long marks (0/1, MSB first) into bytes.
// Define BLINK_PARITY_EN to require a 9th even-parity mark per frame.
module blink_pulse_rx
    import blink_pkg::*;
#(
    parameter int CNT_W           = DEF_CNT_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_THRESH     = DEF_LONG_THRESH,
    parameter int MAX_MARK        = DEF_MAX_MARK,
    parameter int GAP_TIMEOUT     = DEF_GAP_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    blink_pulse_rx_if.slave  bus
);
`ifdef BLINK_PARITY_EN
    localparam int TOTAL_BITS = FRAME_BITS + 1;
`else
    localparam int TOTAL_BITS = FRAME_BITS;
`endif
    localparam logic [3:0]       LAST_BIT = 4'(TOTAL_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LONG_T   = CNT_W'(LONG_THRESH);
    localparam logic [CNT_W-1:0] MAX_T    = CNT_W'(MAX_MARK);
    localparam logic [CNT_W-1:0] GAP_T    = CNT_W'(GAP_TIMEOUT);

    logic w_level;
    logic w_rise;
    logic w_fall;

    blink_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (bus.rx_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    blink_state_e     r_state,     w_state;
    logic [CNT_W-1:0] r_markCnt,   w_markCnt;
    logic [CNT_W-1:0] r_gapCnt,    w_gapCnt;
    logic [7:0]       r_shift,     w_shift;
    logic [3:0]       r_bitCnt,    w_bitCnt;
    logic [7:0]       r_dataOut,   w_dataOut;
    logic             r_dataValid, w_dataValid;
    logic             r_frameErr,  w_frameErr;

    logic [CNT_W-1:0] w_markInc;
    logic [CNT_W-1:0] w_gapInc;
    logic [3:0]       w_bitCntInc;
    logic             w_bit;

    // Saturating increments; the incremented mark count equals the filtered high time at the fall.
    assign w_markInc   = (r_markCnt == CNT_MAX) ? r_markCnt : r_markCnt + CNT_W'(1);
    assign w_gapInc    = (r_gapCnt == CNT_MAX) ? r_gapCnt : r_gapCnt + CNT_W'(1);
    assign w_bitCntInc = r_bitCnt + 4'd1;
    assign w_bit       = (w_markInc >= LONG_T);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_markCnt   <= '0;
            r_gapCnt    <= '0;
            r_shift     <= '0;
            r_bitCnt    <= '0;
            r_dataOut   <= '0;
            r_dataValid <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_markCnt   <= w_markCnt;
            r_gapCnt    <= w_gapCnt;
            r_shift     <= w_shift;
            r_bitCnt    <= w_bitCnt;
            r_dataOut   <= w_dataOut;
            r_dataValid <= w_dataValid;
            r_frameErr  <= w_frameErr;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_markCnt   = r_markCnt;
        w_gapCnt    = r_gapCnt;
        w_shift     = r_shift;
        w_bitCnt    = r_bitCnt;
        w_dataOut   = r_dataOut;
        w_dataValid = 1'b0;
        w_frameErr  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_markCnt = '0;
                    w_state   = MARK;
                end
            end

            MARK: begin
                w_markCnt = w_markInc;
                if (w_fall) begin
                    if (w_markInc > MAX_T) begin
                        w_frameErr = 1'b1;
                        w_bitCnt   = '0;
                        w_state    = IDLE;
                    end else if (w_bitCntInc == LAST_BIT) begin
                        w_bitCnt = '0;
                        w_state  = IDLE;
`ifdef BLINK_PARITY_EN
                        // Even parity: the parity mark equals the XOR of the eight data bits.
                        if (w_bit == ^r_shift) begin
                            w_dataOut   = r_shift;
                            w_dataValid = 1'b1;
                        end else begin
                            w_frameErr  = 1'b1;
                        end
`else
                        w_dataOut   = {r_shift[6:0], w_bit};
                        w_dataValid = 1'b1;
`endif
                    end else begin
                        w_shift  = {r_shift[6:0], w_bit};
                        w_bitCnt = w_bitCntInc;
                        w_gapCnt = '0;
                        w_state  = SPACE;
                    end
                end
            end

            SPACE: begin
                w_gapCnt = w_gapInc;
                if (w_rise) begin
                    w_markCnt = '0;
                    w_state   = MARK;
                end else if (!w_level && (w_gapInc >= GAP_T) &&
                             (r_bitCnt != 4'd0) && (r_bitCnt < LAST_BIT)) begin
                    w_frameErr = 1'b1;
                    w_bitCnt   = '0;
                    w_state    = IDLE;
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign bus.data_out   = r_dataOut;
    assign bus.data_valid = r_dataValid;
    assign bus.frame_err  = r_frameErr;
    assign bus.busy       = (r_state != IDLE);
    assign bus.bit_cnt    = r_bitCnt;
endmodule

// File: tb/tb_blink_pulse_rx.sv
// Self-checking bench for blink_pulse_rx: directed scenarios plus random frames
// scored against a mark/space-level reference model with exact event timing.
module tb_blink_pulse_rx;
    localparam int DB    = 4;
    localparam int LONG  = 20;
    localparam int MAXM  = 60;
    localparam int GAP   = 100;
    localparam int CW    = 8;
    localparam int LAT   = 2 + DB + 1;
`ifdef BLINK_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    typedef struct {
        bit         isErr;
        logic [7:0] data;
        int         cyc;
    } event_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    blink_pulse_rx_if bus();

    blink_pulse_rx #(
        .CNT_W           (CW),
        .DEBOUNCE_CYCLES (DB),
        .LONG_THRESH     (LONG),
        .MAX_MARK        (MAXM),
        .GAP_TIMEOUT     (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int cycleCount = 0;
    always @(posedge clk) cycleCount++;

    int         vectorCount = 0;
    int         miscompares = 0;
    event_t     obsQ[$];
    event_t     expQ[$];
    bit         sawBusy = 0;
    int         modelBits = 0;
    logic [8:0] modelShift = '0;
    logic [7:0] modelData = '0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: records every pulse with the cycle it was seen in.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (bus.busy) sawBusy = 1;
                if (bus.data_valid || bus.frame_err) begin
                    checkOutput("pulse_exclusive", 32'(bus.data_valid & bus.frame_err), 32'd0);
                    obsQ.push_back('{isErr: bus.frame_err, data: bus.data_out, cyc: cycleCount});
                end
            end
        end
    end

    // Reference model working on whole marks: length rules, frame size, parity, gap abort.
    task automatic modelMark(input int len, input int space, input int fallCyc);
        if (len > MAXM) begin
            expQ.push_back('{isErr: 1'b1, data: 8'h00, cyc: fallCyc + LAT});
            modelBits = 0;
            return;
        end
        modelShift = {modelShift[7:0], (len >= LONG) ? 1'b1 : 1'b0};
        modelBits++;
        if (modelBits == NBITS) begin
            modelBits = 0;
            if (NBITS == 9 && (^modelShift) != 1'b0) begin
                expQ.push_back('{isErr: 1'b1, data: 8'h00, cyc: fallCyc + LAT});
            end else begin
                modelData = (NBITS == 9) ? modelShift[8:1] : modelShift[7:0];
                expQ.push_back('{isErr: 1'b0, data: modelData, cyc: fallCyc + LAT});
            end
        end else if (space > GAP) begin
            expQ.push_back('{isErr: 1'b1, data: 8'h00, cyc: fallCyc + LAT + GAP});
            modelBits = 0;
        end
    endtask

    task automatic applyStimulus(input int len, input int space, input bit useModel);
        int fallCyc;
        @(negedge clk);
        bus.rx_in = 1'b1;
        repeat (len) @(negedge clk);
        bus.rx_in = 1'b0;
        fallCyc = cycleCount;
        if (useModel) modelMark(len, space, fallCyc);
        repeat (space - 1) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b, input bit flipParity);
        for (int i = 7; i >= 0; i--) applyStimulus(b[i] ? 30 : 10, 15, 1);
        if (NBITS == 9) applyStimulus(((^b) ^ flipParity) ? 30 : 10, 15, 1);
    endtask

    task automatic checkEvents(input string tag);
        event_t o;
        event_t e;
        repeat (LAT + GAP + 20) @(negedge clk);
        checkOutput({tag, "_count"}, 32'(obsQ.size()), 32'(expQ.size()));
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            o = obsQ.pop_front();
            e = expQ.pop_front();
            checkOutput({tag, "_kind"}, 32'(o.isErr), 32'(e.isErr));
            if (!e.isErr) checkOutput({tag, "_data"}, 32'(o.data), 32'(e.data));
            checkOutput({tag, "_cycle"}, 32'(o.cyc), 32'(e.cyc));
        end
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic resetPulse();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelBits = 0;
        modelData = 8'h00;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] t1Byte;
        int         mode;
        int         stopAt;
        int         lens[9];

        bus.rx_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        checkOutput("rst_data_out", 32'(bus.data_out), 32'h0);
        checkOutput("rst_data_valid", 32'(bus.data_valid), 32'h0);
        checkOutput("rst_frame_err", 32'(bus.frame_err), 32'h0);
        checkOutput("rst_busy", 32'(bus.busy), 32'h0);
        checkOutput("rst_bit_cnt", 32'(bus.bit_cnt), 32'h0);

        $display("[TB] basic frame 0xA6");
        t1Byte = 8'hA6;
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(t1Byte[i] ? 30 : 10, 15, 1);
            if (i == 5) begin
                checkOutput("mid_bit_cnt", 32'(bus.bit_cnt), 32'd3);
                checkOutput("mid_busy", 32'(bus.busy), 32'd1);
            end
        end
        if (NBITS == 9) applyStimulus((^t1Byte) ? 30 : 10, 15, 1);
        checkEvents("t1");
        checkOutput("t1_data_out", 32'(bus.data_out), 32'hA6);
        checkOutput("t1_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        checkOutput("t1_busy", 32'(bus.busy), 32'd0);

        $display("[TB] glitches while idle");
        sawBusy = 0;
        applyStimulus(2, 20, 0);
        applyStimulus(3, 20, 0);
        checkEvents("glitch");
        checkOutput("glitch_busy", 32'(sawBusy), 32'd0);

        $display("[TB] gap timeout abort");
        applyStimulus(30, 15, 1);
        applyStimulus(10, 15, 1);
        applyStimulus(30, 150, 1);
        checkEvents("t3");
        checkOutput("t3_data_out", 32'(bus.data_out), 32'hA6);
        checkOutput("t3_busy", 32'(bus.busy), 32'd0);

        $display("[TB] overlong mark then 0x3C");
        applyStimulus(70, 15, 1);
        sendByte(8'h3C, 0);
        checkEvents("t4");
        checkOutput("t4_data_out", 32'(bus.data_out), 32'h3C);

        $display("[TB] threshold boundaries");
        lens = '{20, 19, 60, 19, 20, 19, 19, 60, 10};
        for (int i = 0; i < NBITS; i++) applyStimulus(lens[i], 15, 1);
        applyStimulus(61, 15, 1);
        checkEvents("bound");
        checkOutput("bound_data_out", 32'(bus.data_out), 32'hA9);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 5; i++) applyStimulus(30, 15, 1);
        resetPulse();
        checkEvents("t5_reset");
        checkOutput("t5_data_out", 32'(bus.data_out), 32'h0);
        checkOutput("t5_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        sendByte(8'hFF, 0);
        checkEvents("t5");
        checkOutput("t5_data_ff", 32'(bus.data_out), 32'hFF);

`ifdef BLINK_PARITY_EN
        $display("[TB] parity check");
        sendByte(8'h01, 0);
        checkEvents("par_ok");
        checkOutput("par_ok_data", 32'(bus.data_out), 32'h01);
        sendByte(8'h01, 1);
        checkEvents("par_bad");
        checkOutput("par_bad_data", 32'(bus.data_out), 32'h01);
`endif

        $display("[TB] random frames");
        for (int f = 0; f < 20; f++) begin
            b      = 8'($urandom);
            mode   = int'($urandom_range(0, 5));
            stopAt = int'($urandom_range(0, NBITS - 2));
            for (int i = 0; i < NBITS; i++) begin
                logic bitVal;
                int   len;
                int   space;
                if (i < 8) bitVal = b[7 - i];
                else       bitVal = (^b) ^ ($urandom_range(0, 3) == 0);
                len   = bitVal ? int'($urandom_range(LONG, MAXM)) : int'($urandom_range(6, LONG - 1));
                space = int'($urandom_range(6, 40));
                if (mode == 0 && i == stopAt) begin
                    space = int'($urandom_range(GAP + 5, GAP + 40));
                end
                if (mode == 1 && i == stopAt) begin
                    len = int'($urandom_range(MAXM + 1, MAXM + 30));
                end
                applyStimulus(len, space, 1);
                if (mode <= 1 && i == stopAt) break;
            end
        end
        checkEvents("rand");
        checkOutput("rand_data_out", 32'(bus.data_out), 32'(modelData));
        checkOutput("rand_busy", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
        $finish;
    end
endmodule
